// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : calc_sequencer
// Keypad-driven operand entry and ALU start/done sequencing for the calculator.
// Rev    : 1.0  initial release
// ============================================================================
module calc_sequencer #(
    parameter int W           = 16,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         alu_start,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic [W-1:0] display,
    output logic [1:0]   disp_sel,
    output logic         new_operation,
    output logic         busy
);
    localparam int                 c_CNT_W    = $clog2(ALU_TIMEOUT) + 1;
    localparam int                 c_EXT_W    = W + 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ALU_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_EXT_W-1:0] c_TEN      = c_EXT_W'(10);

    typedef enum logic [2:0] {
        S_WAIT_A   = 3'd0,
        S_WAIT_B   = 3'd1,
        S_BUSY     = 3'd2,
        S_SHOW_RES = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a, r_b, r_r;
    logic [1:0]         r_op;
    logic               r_b_entered;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_alu_start, r_new_op, r_busy;
    logic [1:0]         r_alu_op, r_disp_sel;
    logic [W-1:0]       r_alu_a, r_alu_b, r_display;

    logic               w_is_digit, w_is_op, w_is_eq, w_is_clr;
    logic [1:0]         w_key_op;
    logic [c_EXT_W-1:0] w_a_dig, w_b_dig;
    logic               w_a_fits, w_b_fits;
    state_t             w_state_n;
    logic [W-1:0]       w_a_n, w_b_n, w_r_n, w_disp_n;
    logic [1:0]         w_op_n, w_sel_n;
    logic               w_bent_n, w_launch, w_chain;

    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    assign w_is_eq    = key_valid && (key_code == 4'd13);
    assign w_is_clr   = key_valid && (key_code == 4'd14);
    assign w_key_op   = (key_code == 4'd10) ? 2'd0 : (key_code == 4'd11) ? 2'd1 : 2'd2;

    // Digit append is evaluated 4 bits wide of the operand so overflow shows up in the top nibble
    assign w_a_dig  = {4'b0000, r_a} * c_TEN + {{W{1'b0}}, key_code};
    assign w_b_dig  = {4'b0000, r_b} * c_TEN + {{W{1'b0}}, key_code};
    assign w_a_fits = ~|w_a_dig[c_EXT_W-1:W];
    assign w_b_fits = ~|w_b_dig[c_EXT_W-1:W];

    always_comb begin
        w_state_n = r_state;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_r_n     = r_r;
        w_op_n    = r_op;
        w_bent_n  = r_b_entered;
        w_launch  = 1'b0;
        w_chain   = 1'b0;
        if (w_is_clr) begin
            w_state_n = S_WAIT_A;
            w_a_n     = '0;
            w_b_n     = '0;
            w_bent_n  = 1'b0;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (w_is_digit) begin
                        if (w_a_fits) w_a_n = w_a_dig[W-1:0];
                    end else if (w_is_op) begin
                        w_op_n    = w_key_op;
                        w_b_n     = '0;
                        w_bent_n  = 1'b0;
                        w_state_n = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (w_is_digit) begin
                        if (w_b_fits) w_b_n = w_b_dig[W-1:0];
                        w_bent_n = 1'b1;
                    end else if (w_is_op) begin
                        if (!r_b_entered) w_op_n = w_key_op;
                    end else if (w_is_eq) begin
                        w_launch  = 1'b1;
                        w_state_n = S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A done on the final timeout cycle still counts as a completion
                    if (alu_done) begin
                        if (alu_ovf) begin
                            w_state_n = S_ERROR;
                        end else begin
                            w_r_n     = alu_result;
                            w_state_n = S_SHOW_RES;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_n = S_ERROR;
                    end
                end
                S_SHOW_RES: begin
                    if (w_is_op) begin
                        w_a_n     = r_r;
                        w_op_n    = w_key_op;
                        w_b_n     = '0;
                        w_bent_n  = 1'b0;
                        w_chain   = 1'b1;
                        w_state_n = S_WAIT_B;
                    end else if (w_is_digit) begin
                        w_a_n     = {{(W-4){1'b0}}, key_code};
                        w_state_n = S_WAIT_A;
                    end
                end
                default: ;
            endcase
        end

        w_disp_n = w_a_n;
        w_sel_n  = 2'd0;
        case (w_state_n)
            S_WAIT_B, S_BUSY: begin
                if (w_bent_n) begin
                    w_disp_n = w_b_n;
                    w_sel_n  = 2'd1;
                end
            end
            S_SHOW_RES: begin
                w_disp_n = w_r_n;
                w_sel_n  = 2'd2;
            end
            S_ERROR: begin
                w_disp_n = '0;
                w_sel_n  = 2'd3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_WAIT_A;
            r_a         <= '0;
            r_b         <= '0;
            r_r         <= '0;
            r_op        <= 2'd0;
            r_b_entered <= 1'b0;
            r_cnt       <= '0;
            r_alu_start <= 1'b0;
            r_new_op    <= 1'b0;
            r_busy      <= 1'b0;
            r_alu_op    <= 2'd0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_display   <= '0;
            r_disp_sel  <= 2'd0;
        end else begin
            r_state     <= w_state_n;
            r_a         <= w_a_n;
            r_b         <= w_b_n;
            r_r         <= w_r_n;
            r_op        <= w_op_n;
            r_b_entered <= w_bent_n;
            r_alu_start <= w_launch;
            r_new_op    <= w_chain;
            r_busy      <= (w_state_n == S_BUSY);
            r_display   <= w_disp_n;
            r_disp_sel  <= w_sel_n;
            if (w_launch) begin
                r_alu_a  <= r_a;
                r_alu_b  <= r_b;
                r_alu_op <= r_op;
                r_cnt    <= '0;
            end else if (r_state == S_BUSY && w_state_n == S_BUSY) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign alu_start     = r_alu_start;
    assign alu_op        = r_alu_op;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign display       = r_display;
    assign disp_sel      = r_disp_sel;
    assign new_operation = r_new_op;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_sequencer
// Table, directed and random checks of calc_sequencer against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;
    localparam int c_MAXV = 65535;
    localparam int c_TO   = 64;
    localparam int M_WA = 0, M_WB = 1, M_BUSY = 2, M_RES = 3, M_ERR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        alu_ovf = 1'b0;
    logic [15:0] display;
    logic [1:0]  disp_sel;
    logic        new_operation;
    logic        busy;

    calc_sequencer #(.W(16), .ALU_TIMEOUT(c_TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .display(display), .disp_sel(disp_sel), .new_operation(new_operation),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: calculator behaviour in plain integers
    int m_mode, m_a, m_b, m_r, m_op, m_bdig, m_elapsed;
    int m_alu_a, m_alu_b, m_alu_op, m_start, m_newop;

    task automatic model_reset();
        m_mode = M_WA; m_a = 0; m_b = 0; m_r = 0; m_op = 0; m_bdig = 0; m_elapsed = 0;
        m_alu_a = 0; m_alu_b = 0; m_alu_op = 0; m_start = 0; m_newop = 0;
    endtask

    task automatic model_edge(input int kv, input int kc, input int dn, input int res, input int ovf);
        bit is_dig, is_op;
        is_dig  = (kv != 0) && kc <= 9;
        is_op   = (kv != 0) && kc >= 10 && kc <= 12;
        m_start = 0;
        m_newop = 0;
        if (kv != 0 && kc == 14) begin
            m_mode = M_WA; m_a = 0; m_b = 0; m_bdig = 0;
        end else if (m_mode == M_WA) begin
            if (is_dig) begin
                if (m_a * 10 + kc <= c_MAXV) m_a = m_a * 10 + kc;
            end else if (is_op) begin
                m_op = kc - 10; m_b = 0; m_bdig = 0; m_mode = M_WB;
            end
        end else if (m_mode == M_WB) begin
            if (is_dig) begin
                if (m_b * 10 + kc <= c_MAXV) m_b = m_b * 10 + kc;
                m_bdig = 1;
            end else if (is_op) begin
                if (m_bdig == 0) m_op = kc - 10;
            end else if (kv != 0 && kc == 13) begin
                m_alu_a = m_a; m_alu_b = m_b; m_alu_op = m_op;
                m_start = 1; m_elapsed = 0; m_mode = M_BUSY;
            end
        end else if (m_mode == M_BUSY) begin
            m_elapsed++;
            if (dn != 0) begin
                if (ovf != 0) m_mode = M_ERR;
                else begin m_r = res; m_mode = M_RES; end
            end else if (m_elapsed == c_TO) begin
                m_mode = M_ERR;
            end
        end else if (m_mode == M_RES) begin
            if (is_op) begin
                m_a = m_r; m_op = kc - 10; m_b = 0; m_bdig = 0; m_newop = 1; m_mode = M_WB;
            end else if (is_dig) begin
                m_a = kc; m_mode = M_WA;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        int ed, es;
        case (m_mode)
            M_RES:   begin ed = m_r; es = 2; end
            M_ERR:   begin ed = 0;   es = 3; end
            M_WB, M_BUSY: begin
                if (m_bdig != 0) begin ed = m_b; es = 1; end
                else begin ed = m_a; es = 0; end
            end
            default: begin ed = m_a; es = 0; end
        endcase
        check("display",       32'(display),       32'(ed));
        check("disp_sel",      32'(disp_sel),      32'(es));
        check("alu_start",     32'(alu_start),     32'(m_start));
        check("new_operation", 32'(new_operation), 32'(m_newop));
        check("busy",          32'(busy),          32'(m_mode == M_BUSY));
        check("alu_a",         32'(alu_a),         32'(m_alu_a));
        check("alu_b",         32'(alu_b),         32'(m_alu_b));
        check("alu_op",        32'(alu_op),        32'(m_alu_op));
    endtask

    task automatic step(input int kv, input int kc, input int dn, input int res, input int ovf);
        key_valid  = kv[0];
        key_code   = kc[3:0];
        alu_done   = dn[0];
        alu_result = res[15:0];
        alu_ovf    = ovf[0];
        @(posedge clk);
        model_edge(kv, kc, dn, res, ovf);
        #1;
        compare_all();
        key_valid = 1'b0;
        alu_done  = 1'b0;
        alu_ovf   = 1'b0;
    endtask

    task automatic key(input int kc);
        step(1, kc, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    typedef struct {
        int kv, kc, dn, res, ovf;
        int disp, sel, start, newop, bsy;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input int kv, kc, dn, res, ovf, disp, sel, start, newop, bsy);
        vec_t v;
        v = '{kv, kc, dn, res, ovf, disp, sel, start, newop, bsy};
        tbl.push_back(v);
    endtask

    initial begin
        int kv, kc, dn, res, ovf;

        // kv kc dn res ovf | disp sel start newop busy
        add_vec(1,  1, 0,  0, 0,   1, 0, 0, 0, 0);
        add_vec(1,  2, 0,  0, 0,  12, 0, 0, 0, 0);
        add_vec(1, 10, 0,  0, 0,  12, 0, 0, 0, 0);
        add_vec(1,  3, 0,  0, 0,   3, 1, 0, 0, 0);
        add_vec(1, 13, 0,  0, 0,   3, 1, 1, 0, 1);
        add_vec(0,  0, 1, 15, 0,  15, 2, 0, 0, 0);
        add_vec(1, 11, 0,  0, 0,  15, 0, 0, 1, 0);
        add_vec(1,  5, 0,  0, 0,   5, 1, 0, 0, 0);
        add_vec(1, 13, 0,  0, 0,   5, 1, 1, 0, 1);
        add_vec(0,  0, 1, 10, 0,  10, 2, 0, 0, 0);
        add_vec(1, 13, 0,  0, 0,  10, 2, 0, 0, 0);
        add_vec(1,  7, 0,  0, 0,   7, 0, 0, 0, 0);
        add_vec(1, 12, 0,  0, 0,   7, 0, 0, 0, 0);
        add_vec(1, 10, 0,  0, 0,   7, 0, 0, 0, 0);
        add_vec(1, 11, 0,  0, 0,   7, 0, 0, 0, 0);
        add_vec(1,  4, 0,  0, 0,   4, 1, 0, 0, 0);
        add_vec(1, 10, 0,  0, 0,   4, 1, 0, 0, 0);
        add_vec(1, 13, 0,  0, 0,   4, 1, 1, 0, 1);
        add_vec(0,  0, 1, 99, 1,   0, 3, 0, 0, 0);
        add_vec(1,  5, 0,  0, 0,   0, 3, 0, 0, 0);
        add_vec(1, 10, 0,  0, 0,   0, 3, 0, 0, 0);
        add_vec(1, 14, 0,  0, 0,   0, 0, 0, 0, 0);
        add_vec(0,  5, 0,  0, 0,   0, 0, 0, 0, 0);
        add_vec(1, 15, 0,  0, 0,   0, 0, 0, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].kv, tbl[i].kc, tbl[i].dn, tbl[i].res, tbl[i].ovf);
            check("tbl_display",  32'(display),       32'(tbl[i].disp));
            check("tbl_disp_sel", 32'(disp_sel),      32'(tbl[i].sel));
            check("tbl_start",    32'(alu_start),     32'(tbl[i].start));
            check("tbl_newop",    32'(new_operation), 32'(tbl[i].newop));
            check("tbl_busy",     32'(busy),          32'(tbl[i].bsy));
            if (i == 17) begin
                check("tbl_last_op_used", 32'(alu_op), 32'd1);
                check("tbl_alu_a",        32'(alu_a),  32'd7);
                check("tbl_alu_b",        32'(alu_b),  32'd4);
            end
        end

        // Operand saturation at 2^16-1
        key(14); key(6); key(5); key(5); key(3); key(5);
        check("ovf_a_max", 32'(display), 32'd65535);
        key(0);
        check("ovf_a_hold", 32'(display), 32'd65535);

        // Timeout: error exactly after 64 BUSY cycles
        key(10); key(13);
        idle(c_TO - 1);
        check("timeout_not_yet", 32'(busy), 32'd1);
        idle(1);
        check("timeout_error", 32'(disp_sel), 32'd3);
        key(14);

        // Done on the timeout cycle wins over the timeout
        key(2); key(10); key(2); key(13);
        idle(c_TO - 1);
        step(0, 0, 1, 4, 0);
        check("done_beats_timeout_sel", 32'(disp_sel), 32'd2);
        check("done_beats_timeout_val", 32'(display),  32'd4);

        // Clear during BUSY, then a late done
        key(14); key(3); key(12); key(3); key(13);
        key(14);
        check("clr_busy_busy", 32'(busy), 32'd0);
        idle(1);
        step(0, 0, 1, 9, 0);
        check("late_done_sel",  32'(disp_sel), 32'd0);
        check("late_done_disp", 32'(display),  32'd0);

        // Clear and done in the same cycle
        key(1); key(10); key(1); key(13);
        step(1, 14, 1, 2, 0);
        check("clr_vs_done_sel",  32'(disp_sel), 32'd0);
        check("clr_vs_done_disp", 32'(display),  32'd0);

        // Asynchronous reset mid-cycle while BUSY
        key(8); key(10); key(9); key(13);
        #2 rst = 1'b1;
        #1;
        check("arst_alu_start", 32'(alu_start), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_alu_a",     32'(alu_a),     32'd0);
        check("arst_alu_b",     32'(alu_b),     32'd0);
        check("arst_display",   32'(display),   32'd0);
        check("arst_disp_sel",  32'(disp_sel),  32'd0);
        model_reset();
        #1 rst = 1'b0;
        step(0, 0, 1, 77, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            kv  = ($urandom_range(0, 99) < 40) ? 1 : 0;
            kc  = $urandom_range(0, 15);
            if (m_mode == M_BUSY) dn = ($urandom_range(0, 99) < 30) ? 1 : 0;
            else                  dn = ($urandom_range(0, 99) < 5) ? 1 : 0;
            res = $urandom_range(0, 65535);
            ovf = ($urandom_range(0, 99) < 20) ? 1 : 0;
            step(kv, kc, dn, res, ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level controller for the calculator datapath. It turns single-cycle keypad events into operand entry and sequences one shared ALU through a start/done handshake. It selects what the display shows and handles chained operations, errors and clear. It sits between the keypad decoder and the ALU/display path, replacing ad-hoc state tracking with a single owner of the calculation sequence.

## Interface
- W, 16, operand/result width in bits (unsigned)
- ALU_TIMEOUT, 64, max cycles from alu_start to alu_done before error

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0–9 digit, 10 add, 11 sub, 12 mul, 13 eq, 14 clear, 15 ignored
- alu_start  out  1  one-cycle pulse launching an operation
- alu_op  out  2  0 add, 1 sub, 2 mul; held while busy
- alu_a, alu_b  out  W  operands; held while busy
- alu_done  in  1  one-cycle completion strobe
- alu_result  in  W  valid with alu_done
- alu_ovf  in  1  valid with alu_done; overflow/negative
- display  out  W  value to show
- disp_sel  out  2  0 operand A, 1 operand B, 2 result, 3 error
- new_operation  out  1  one-cycle pulse when a result is chained as operand A
- busy  out  1  high in BUSY state

## Operation
- States: WAIT_A, WAIT_B, BUSY, SHOW_RES, ERROR. Reset state is WAIT_A.
- Reset values: all outputs 0, A = B = 0, op = add, timeout counter = 0.
- A key is accepted only on a cycle where key_valid = 1.
- clear (14) is accepted in every state, including BUSY. It sets A = B = 0 and goes to WAIT_A.
- Digit d in WAIT_A updates A to A*10+d; in WAIT_B it updates B to B*10+d.
  - If the new value exceeds 2^W−1, the digit is dropped and the operand is unchanged.
  - Arithmetic is done at W+4 bits before the compare.
- Operator key:
  - WAIT_A: latch op, set B = 0, go to WAIT_B.
  - WAIT_B with no digit entered yet: replace op and stay.
  - WAIT_B with a digit entered: ignored.
- eq (13):
  - WAIT_A: ignored.
  - WAIT_B: drive alu_a = A, alu_b = B, alu_op = op, pulse alu_start, go to BUSY.
- BUSY: every key except clear is ignored.
  - alu_done with alu_ovf = 0: R = alu_result, go to SHOW_RES.
  - alu_done with alu_ovf = 1: go to ERROR.
  - Counter reaches ALU_TIMEOUT without alu_done: go to ERROR.
- SHOW_RES:
  - Operator: A = R, latch op, B = 0, pulse new_operation, go to WAIT_B.
  - Digit d: A = d, go to WAIT_A.
  - eq: ignored; no repeat-last-op.
- ERROR: only clear exits. disp_sel = 3, display = 0.
- Display: disp_sel 0 shows A, 1 shows B, 2 shows R.
  - WAIT_B shows A until the first B digit is entered, then shows B.
- alu_done outside BUSY is ignored, e.g. a late done after a clear abort.

## Timing
- All outputs are registered. A key accepted at edge N is reflected in state and outputs after edge N.
- alu_start is high for exactly the one cycle after the eq edge. alu_a, alu_b and alu_op are stable from that cycle until BUSY exits.
- The timeout counter starts at 0 on the alu_start cycle and increments each cycle in BUSY. ERROR is entered on the edge where count = ALU_TIMEOUT−1 and alu_done = 0.
- If alu_done and timeout occur in the same cycle, alu_done wins.
- If clear and alu_done occur in the same cycle, clear wins; the result is discarded.
- Minimum latency from eq to SHOW_RES is 2 edges, given alu_done in the cycle after alu_start.
- rst asserted mid-operation clears everything immediately, without waiting for a clock edge. alu_start drops at once.

## Test plan
- Digits 1,2, add, 3, eq, alu_done with result 15 one cycle after start:
  - alu_a = 12, alu_b = 3, alu_op = 0, one alu_start pulse.
  - Ends with disp_sel = 2, display = 15.
- Chaining: after result 15, press sub:
  - new_operation pulses once, disp_sel = 0 showing 15.
  - Then 5, eq, alu_done with 10 gives display = 10.
- Digit overflow with W=16:
  - Enter 6,5,5,3,5: A = 65535.
  - A further digit 0 leaves A = 65535.
- ALU error paths:
  - alu_done with alu_ovf = 1 goes to ERROR, disp_sel = 3; digits and ops are ignored; clear returns to WAIT_A, display = 0.
  - No alu_done for 64 cycles after start also gives ERROR.
- Clear during BUSY, then alu_done 2 cycles later:
  - State is WAIT_A and display stays 0.
  - A late alu_done in the same cycle as clear is also discarded.
- Asynchronous rst pulse between clock edges while in BUSY:
  - All outputs go to 0 before the next edge; state is WAIT_A.
  - Operator pressed twice in WAIT_B before any digit: the last op is used.
